// File: rtl/adv_config_pkg.sv
// Shared definitions for the ADV7513 power-up configuration sequencer.
//   cfg_state_e   : sequencer FSM states
//   ADV_DEV_ADDR  : 7-bit I2C address of the ADV7513
//   ADV_TABLE     : {reg_addr, reg_data} write list, applied in index order
package adv_config_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_DONE,
      ST_NEXT,
      ST_DONE,
      ST_ERROR
   } cfg_state_e;

   localparam logic [6:0] ADV_DEV_ADDR  = 7'h39;
   localparam int         ADV_TABLE_LEN = 16;

   // The first nine entries are the mandatory power-up writes; the rest set
   // up a plain 24-bit RGB 4:4:4 HDMI output.
   localparam logic [15:0] ADV_TABLE [ADV_TABLE_LEN] = '{
      16'h41_10,  // power up
      16'h98_03,  // fixed
      16'h9A_E0,  // fixed
      16'h9C_30,  // fixed
      16'h9D_61,  // fixed
      16'hA2_A4,  // fixed
      16'hA3_A4,  // fixed
      16'hE0_D0,  // fixed
      16'hF9_00,  // fixed
      16'h15_00,  // input ID: 24-bit RGB 4:4:4
      16'h16_30,  // output 4:4:4, 8 bit
      16'h17_02,  // 16:9 aspect
      16'h18_46,  // CSC disabled
      16'hAF_06,  // HDMI mode
      16'hBA_60,  // clock delay
      16'hD6_C0   // HPD forced high internally
   };

endpackage

// File: rtl/adv_config_rom.sv
// Combinational lookup of the configuration table.
//   index    : table entry number
//   reg_addr : ADV7513 register address of that entry (0 past the table end)
//   reg_data : value written to that register (0 past the table end)
module adv_config_rom
   import adv_config_pkg::*;
(
   input  logic [7:0] index,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_data
);

   logic [15:0] entry;

   always_comb begin
      entry = 16'h0000;
      if (index < 8'(ADV_TABLE_LEN)) entry = ADV_TABLE[index[3:0]];
   end

   assign reg_addr = entry[15:8];
   assign reg_data = entry[7:0];

endmodule

// File: rtl/adv_config_sequencer.sv
// Writes the ADV7513 configuration table over an external I2C master, with
// retry on NACK/timeout and restart on a debounced hot-plug detect.
//   Clock, Reset_n      : sequencer clock, async active-low reset
//   Start               : one-cycle request to run the table
//   HPD                 : raw hot-plug detect (asynchronous)
//   I2C_Req/DevAddr/RegAddr/RegData : write request to the master
//   I2C_Done, I2C_Nack  : end-of-transaction pulse and its NACK flag
//   Busy, Cfg_Done, Cfg_Error, Err_Index : sequence status
//
// state        | meaning
// ST_IDLE      | nothing run yet, or sequence abandoned after HPD loss
// ST_ISSUE     | one-cycle I2C_Req for the current entry
// ST_WAIT_DONE | waiting for I2C_Done or the timeout
// ST_NEXT      | entry accepted, advance the index
// ST_DONE      | whole table written
// ST_ERROR     | retries exhausted on Err_Index
module adv_config_sequencer #(
   parameter int         NUM_REGS     = 16,
   parameter logic [6:0] DEV_ADDR     = adv_config_pkg::ADV_DEV_ADDR,
   parameter int         DEBOUNCE_CYC = 1000,
   parameter int         RETRY_MAX    = 3,
   parameter int         TIMEOUT_CYC  = 4096
) (
   input  logic       Clock,
   input  logic       Reset_n,
   input  logic       Start,
   input  logic       HPD,
   output logic       I2C_Req,
   output logic [6:0] I2C_DevAddr,
   output logic [7:0] I2C_RegAddr,
   output logic [7:0] I2C_RegData,
   input  logic       I2C_Done,
   input  logic       I2C_Nack,
   output logic       Busy,
   output logic       Cfg_Done,
   output logic       Cfg_Error,
   output logic [7:0] Err_Index
);
   import adv_config_pkg::*;

   localparam int DW = $clog2(DEBOUNCE_CYC + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int RW = $clog2(RETRY_MAX + 2);
   localparam logic [DW-1:0] DB_RELOAD = DW'(DEBOUNCE_CYC - 1);
   localparam logic [TW-1:0] TO_RELOAD = TW'(TIMEOUT_CYC - 1);
   localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);
   localparam logic [7:0]    LAST_IDX  = 8'(NUM_REGS - 1);

   cfg_state_e    state, state_nxt;
   logic [7:0]    idx, idx_nxt;
   logic [RW-1:0] retry, retry_nxt;
   logic [TW-1:0] to_cnt;
   logic [DW-1:0] db_cnt;
   logic          hpd_meta, hpd_sync, hpd_ok, hpd_ok_d;
   logic          hpd_rise, hpd_fall;
   logic          abort_pend, abort_nxt;
   logic          done_nxt, error_nxt, busy;
   logic [7:0]    err_idx_nxt;

   // HPD must disagree with the accepted level for DEBOUNCE_CYC consecutive
   // cycles before the new level is taken.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         hpd_meta <= 1'b0;
         hpd_sync <= 1'b0;
         hpd_ok   <= 1'b0;
         hpd_ok_d <= 1'b0;
         db_cnt   <= DB_RELOAD;
      end else begin
         hpd_meta <= HPD;
         hpd_sync <= hpd_meta;
         hpd_ok_d <= hpd_ok;
         if (hpd_sync == hpd_ok) begin
            db_cnt <= DB_RELOAD;
         end else if (db_cnt == '0) begin
            hpd_ok <= hpd_sync;
            db_cnt <= DB_RELOAD;
         end else begin
            db_cnt <= db_cnt - 1'b1;
         end
      end
   end

   assign hpd_rise = hpd_ok & ~hpd_ok_d;
   assign hpd_fall = ~hpd_ok & hpd_ok_d;

   // Reloaded on every issue; reaching zero in WAIT_DONE means TIMEOUT_CYC
   // waiting cycles have passed without I2C_Done.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         to_cnt <= TO_RELOAD;
      end else if (state == ST_ISSUE) begin
         to_cnt <= TO_RELOAD;
      end else if (state == ST_WAIT_DONE && to_cnt != '0) begin
         to_cnt <= to_cnt - 1'b1;
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= ST_IDLE;
         idx        <= '0;
         retry      <= '0;
         abort_pend <= 1'b0;
         Cfg_Done   <= 1'b0;
         Cfg_Error  <= 1'b0;
         Err_Index  <= '0;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         retry      <= retry_nxt;
         abort_pend <= abort_nxt;
         Cfg_Done   <= done_nxt;
         Cfg_Error  <= error_nxt;
         Err_Index  <= err_idx_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      idx_nxt     = idx;
      retry_nxt   = retry;
      done_nxt    = Cfg_Done;
      error_nxt   = Cfg_Error;
      err_idx_nxt = Err_Index;
      busy        = (state == ST_ISSUE) || (state == ST_WAIT_DONE) || (state == ST_NEXT);
      // HPD loss is remembered so the outstanding transaction can finish first.
      abort_nxt   = abort_pend || (busy && hpd_fall);
      case (state)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (Start || hpd_rise) begin
               state_nxt = ST_ISSUE;
               idx_nxt   = '0;
               retry_nxt = '0;
               done_nxt  = 1'b0;
               error_nxt = 1'b0;
               abort_nxt = 1'b0;
            end
         end
         ST_ISSUE: state_nxt = ST_WAIT_DONE;
         ST_WAIT_DONE: begin
            if (I2C_Done || to_cnt == '0) begin
               if (abort_nxt) begin
                  state_nxt = ST_IDLE;
                  abort_nxt = 1'b0;
                  done_nxt  = 1'b0;
                  error_nxt = 1'b0;
               end else if (I2C_Done && !I2C_Nack) begin
                  state_nxt = ST_NEXT;
               end else if (retry < RETRY_LIM) begin
                  retry_nxt = retry + 1'b1;
                  state_nxt = ST_ISSUE;
               end else begin
                  state_nxt   = ST_ERROR;
                  error_nxt   = 1'b1;
                  err_idx_nxt = idx;
               end
            end
         end
         ST_NEXT: begin
            retry_nxt = '0;
            idx_nxt   = idx + 8'd1;
            if (abort_nxt) begin
               state_nxt = ST_IDLE;
               abort_nxt = 1'b0;
               done_nxt  = 1'b0;
               error_nxt = 1'b0;
            end else if (idx == LAST_IDX) begin
               state_nxt = ST_DONE;
               done_nxt  = 1'b1;
            end else begin
               state_nxt = ST_ISSUE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign Busy        = busy;
   assign I2C_Req     = (state == ST_ISSUE);
   assign I2C_DevAddr = DEV_ADDR;

   adv_config_rom u_rom (
      .index    (idx),
      .reg_addr (I2C_RegAddr),
      .reg_data (I2C_RegData)
   );

endmodule

// File: tb/tb_adv_config_sequencer.sv
module tb_adv_config_sequencer;

   localparam int         NUM_REGS     = 16;
   localparam logic [6:0] DEV_ADDR     = 7'h39;
   localparam int         DEBOUNCE_CYC = 6;
   localparam int         RETRY_MAX    = 3;
   localparam int         TIMEOUT_CYC  = 40;

   localparam int RESP_ACK    = 0;
   localparam int RESP_NACK   = 1;
   localparam int RESP_SILENT = 2;
   localparam int RESP_STALE  = 3;

   localparam logic [15:0] REF_TABLE [16] = '{
      16'h4110, 16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61, 16'hA2A4, 16'hA3A4, 16'hE0D0,
      16'hF900, 16'h1500, 16'h1630, 16'h1702, 16'h1846, 16'hAF06, 16'hBA60, 16'hD6C0
   };

   typedef struct packed {
      int idx;
      int resp;
      int delay;
   } txn_t;

   logic       Clock = 1'b0;
   logic       Reset_n, Start, HPD, I2C_Done, I2C_Nack;
   logic       I2C_Req, Busy, Cfg_Done, Cfg_Error;
   logic [6:0] I2C_DevAddr;
   logic [7:0] I2C_RegAddr, I2C_RegData, Err_Index;

   txn_t   exp_q[$];
   int     errors = 0;
   int     checks = 0;
   int     req_count = 0;
   longint cyc = 0;

   adv_config_sequencer #(
      .NUM_REGS     (NUM_REGS),
      .DEV_ADDR     (DEV_ADDR),
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .RETRY_MAX    (RETRY_MAX),
      .TIMEOUT_CYC  (TIMEOUT_CYC)
   ) dut (
      .Clock       (Clock),
      .Reset_n     (Reset_n),
      .Start       (Start),
      .HPD         (HPD),
      .I2C_Req     (I2C_Req),
      .I2C_DevAddr (I2C_DevAddr),
      .I2C_RegAddr (I2C_RegAddr),
      .I2C_RegData (I2C_RegData),
      .I2C_Done    (I2C_Done),
      .I2C_Nack    (I2C_Nack),
      .Busy        (Busy),
      .Cfg_Done    (Cfg_Done),
      .Cfg_Error   (Cfg_Error),
      .Err_Index   (Err_Index)
   );

   always #5 Clock = ~Clock;
   always @(posedge Clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int idx, input int resp, input int delay);
      txn_t t;
      t.idx   = idx;
      t.resp  = resp;
      t.delay = delay;
      exp_q.push_back(t);
   endtask

   task automatic push_range(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) push(i, RESP_ACK, 2);
   endtask

   task automatic pulse_start();
      @(posedge Clock); #1 Start = 1'b1;
      @(posedge Clock); #1 Start = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int k;
      for (k = 0; k < 3000 && !(exp_q.size() == 0 && Busy === 1'b0); k++) @(negedge Clock);
      if (!(exp_q.size() == 0 && Busy === 1'b0)) begin
         checks++;
         errors++;
         $error("FAIL %s: idle wait expired, busy=%0b pending=%0d required busy=0 pending=0",
                tag, Busy, exp_q.size());
      end
   endtask

   task automatic wait_reqs(input string tag, input int target);
      for (int k = 0; k < 400 && req_count < target; k++) @(negedge Clock);
      if (req_count < target) begin
         checks++;
         errors++;
         $error("FAIL %s: request count %0d required %0d", tag, req_count, target);
      end
   endtask

   // I2C master model: pops the scripted transaction, checks the request
   // against the reference table, then answers as the script says.
   initial begin : responder
      txn_t   t;
      longint req_cyc;
      longint silent_cyc;
      bit     prev_silent;
      I2C_Done    = 1'b0;
      I2C_Nack    = 1'b0;
      prev_silent = 1'b0;
      silent_cyc  = 0;
      forever begin
         @(negedge Clock);
         if (I2C_Req === 1'b1) begin
            req_count++;
            req_cyc = cyc;
            if (exp_q.size() == 0) begin
               check("req_unexpected", 32'(I2C_Req), 32'd0);
            end else begin
               t = exp_q.pop_front();
               check("req_entry", {16'd0, I2C_RegAddr, I2C_RegData}, {16'd0, REF_TABLE[t.idx[3:0]]});
               check("dev_addr", 32'(I2C_DevAddr), 32'(DEV_ADDR));
               if (prev_silent) begin
                  // Req cycle, TIMEOUT_CYC waiting cycles, then the reissue.
                  check("timeout_gap", 32'(req_cyc - silent_cyc), 32'(TIMEOUT_CYC + 1));
                  prev_silent = 1'b0;
               end
               @(negedge Clock);
               check("req_one_cycle", 32'(I2C_Req), 32'd0);
               if (t.resp == RESP_SILENT) begin
                  prev_silent = 1'b1;
                  silent_cyc  = req_cyc;
               end else if (t.resp == RESP_STALE) begin
                  for (int k = 0; k < 200 && Reset_n !== 1'b0; k++) @(negedge Clock);
                  for (int k = 0; k < 200 && Reset_n !== 1'b1; k++) @(negedge Clock);
                  @(posedge Clock); #1 I2C_Done = 1'b1;
                  @(posedge Clock); #1 I2C_Done = 1'b0;
               end else begin
                  repeat (t.delay) @(posedge Clock);
                  #1;
                  I2C_Done = 1'b1;
                  I2C_Nack = (t.resp == RESP_NACK);
                  @(negedge Clock);
                  check("regs_held", {16'd0, I2C_RegAddr, I2C_RegData}, {16'd0, REF_TABLE[t.idx[3:0]]});
                  @(posedge Clock); #1;
                  I2C_Done = 1'b0;
                  I2C_Nack = 1'b0;
               end
            end
         end
      end
   end

   initial begin : main
      int base;
      Reset_n = 1'b0;
      Start   = 1'b0;
      HPD     = 1'b0;
      repeat (3) @(posedge Clock);
      #2;
      check("rst_req",     32'(I2C_Req),   32'd0);
      check("rst_busy",    32'(Busy),      32'd0);
      check("rst_done",    32'(Cfg_Done),  32'd0);
      check("rst_error",   32'(Cfg_Error), 32'd0);
      check("rst_err_idx", 32'(Err_Index), 32'd0);
      @(posedge Clock); #1 Reset_n = 1'b1;
      check("dev_addr_const", 32'(I2C_DevAddr), 32'h39);

      // Full table, every entry ACKed; a Start in the middle is ignored.
      base = req_count;
      push_range(0, 15);
      pulse_start();
      repeat (20) @(posedge Clock);
      #1 Start = 1'b1;
      @(posedge Clock); #1 Start = 1'b0;
      @(negedge Clock);
      check("busy_mid_seq", 32'(Busy), 32'd1);
      wait_idle("all_ack");
      check("all_ack_done",  32'(Cfg_Done),  32'd1);
      check("all_ack_error", 32'(Cfg_Error), 32'd0);
      check("all_ack_reqs",  32'(req_count - base), 32'd16);

      // Entry 3 NACKed twice, then accepted.
      base = req_count;
      push_range(0, 2);
      push(3, RESP_NACK, 2);
      push(3, RESP_NACK, 2);
      push(3, RESP_ACK, 2);
      push_range(4, 15);
      pulse_start();
      @(negedge Clock);
      check("done_cleared_on_start", 32'(Cfg_Done), 32'd0);
      wait_idle("nack_retry");
      check("nack_retry_done",  32'(Cfg_Done),  32'd1);
      check("nack_retry_error", 32'(Cfg_Error), 32'd0);
      check("nack_retry_reqs",  32'(req_count - base), 32'd18);

      // Entry 5 NACKed on the first try and all three retries.
      base = req_count;
      push_range(0, 4);
      repeat (RETRY_MAX + 1) push(5, RESP_NACK, 2);
      pulse_start();
      wait_idle("retry_exhaust");
      check("exhaust_error",   32'(Cfg_Error), 32'd1);
      check("exhaust_err_idx", 32'(Err_Index), 32'd5);
      check("exhaust_done",    32'(Cfg_Done),  32'd0);
      repeat (50) @(negedge Clock);
      check("exhaust_no_more_reqs", 32'(req_count - base), 32'd9);

      // Entry 1 gets no Done at all, then is retried and accepted.
      base = req_count;
      push(0, RESP_ACK, 2);
      push(1, RESP_SILENT, 0);
      push(1, RESP_ACK, 2);
      push_range(2, 15);
      pulse_start();
      @(negedge Clock);
      check("error_cleared_on_start", 32'(Cfg_Error), 32'd0);
      wait_idle("timeout");
      check("timeout_done", 32'(Cfg_Done), 32'd1);
      check("timeout_reqs", 32'(req_count - base), 32'd17);

      // HPD glitch shorter than the debounce window.
      base = req_count;
      @(posedge Clock); #1 HPD = 1'b1;
      repeat (DEBOUNCE_CYC - 2) @(posedge Clock);
      #1 HPD = 1'b0;
      repeat (30) @(negedge Clock);
      check("glitch_busy", 32'(Busy), 32'd0);
      check("glitch_reqs", 32'(req_count - base), 32'd0);
      check("glitch_done_kept", 32'(Cfg_Done), 32'd1);

      // Stable HPD starts a run; HPD drops while entry 7 is outstanding.
      base = req_count;
      push_range(0, 6);
      push(7, RESP_ACK, 25);
      @(posedge Clock); #1 HPD = 1'b1;
      wait_reqs("hpd_start", base + 8);
      @(posedge Clock); #1 HPD = 1'b0;
      repeat (15) @(negedge Clock);
      check("hpd_drop_waits_done", 32'(Busy), 32'd1);
      wait_idle("hpd_drop");
      check("hpd_drop_done",  32'(Cfg_Done),  32'd0);
      check("hpd_drop_error", 32'(Cfg_Error), 32'd0);
      repeat (20) @(negedge Clock);
      check("hpd_drop_reqs", 32'(req_count - base), 32'd8);

      // Reset pulsed during WAIT_DONE, stale Done afterwards, then a rerun.
      base = req_count;
      push_range(0, 1);
      push(2, RESP_STALE, 0);
      pulse_start();
      wait_reqs("rst_mid_reach", base + 3);
      repeat (3) @(negedge Clock);
      check("rst_mid_busy_before", 32'(Busy), 32'd1);
      #2 Reset_n = 1'b0;
      #1;
      check("rst_mid_busy",    32'(Busy),      32'd0);
      check("rst_mid_req",     32'(I2C_Req),   32'd0);
      check("rst_mid_error",   32'(Cfg_Error), 32'd0);
      check("rst_mid_err_idx", 32'(Err_Index), 32'd0);
      repeat (3) @(posedge Clock);
      #1 Reset_n = 1'b1;
      repeat (10) @(negedge Clock);
      check("stale_done_busy", 32'(Busy), 32'd0);
      check("stale_done_reqs", 32'(req_count - base), 32'd3);
      push_range(0, 15);
      pulse_start();
      wait_idle("rerun");
      check("rerun_done", 32'(Cfg_Done), 32'd1);
      check("rerun_reqs", 32'(req_count - base), 32'd19);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
